// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcodes, control-code type and FSM states shared by alu_mc
// Revision: 1.0
// ============================================================================
package alu_pkg;

  typedef logic [3:0] alucontrol_t;

  localparam alucontrol_t ALU_AND  = 4'b0000;
  localparam alucontrol_t ALU_OR   = 4'b0001;
  localparam alucontrol_t ALU_ADD  = 4'b0100;
  localparam alucontrol_t ALU_SUB  = 4'b1100;
  localparam alucontrol_t ALU_SLTU = 4'b1110;
  localparam alucontrol_t ALU_SLL  = 4'b0010;
  localparam alucontrol_t ALU_SRL  = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_mc_comb.sv
`default_nettype none
// ============================================================================
// alu_mc_comb : single-cycle and/or/add/sub/sltu evaluation and illegal flag
// Revision: 1.0   (ALU_MC_SRL_EN makes 0011 a legal code)
// ============================================================================
module alu_mc_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             illegal
);

  always_comb begin
    y       = '0;
    illegal = 1'b0;
    case (op)
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLTU: y = {{(WIDTH-1){1'b0}}, (a < b)};
      // Shift codes yield b here: the zero-amount result; nonzero amounts iterate
      ALU_SLL:  y = b;
`ifdef ALU_MC_SRL_EN
      ALU_SRL:  y = b;
`endif
      default:  illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// alu_mc : multi-cycle ALU, single-cycle logic/arith, bit-serial shifts,
//          start/ready/done handshake. Optional srl via ALU_MC_SRL_EN.
// Revision: 1.0
// ============================================================================
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         alucontrol,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal
);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_step;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   comb_y;
  logic               comb_illegal;
  logic               is_shift;
  logic               load_imm;
  logic               load_shift;
  logic               commit_shift;

  // Inputs are only consumed on the accepting edge, which is what latches them
  alu_mc_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .op      (alucontrol),
    .a       (a),
    .b       (b),
    .y       (comb_y),
    .illegal (comb_illegal)
  );

`ifdef ALU_MC_SRL_EN
  logic dir_right;

  assign is_shift  = (alucontrol == ALU_SLL) || (alucontrol == ALU_SRL);
  assign work_step = dir_right ? (work >> 1) : (work << 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_right <= 1'b0;
    end else if (load_shift) begin
      dir_right <= (alucontrol == ALU_SRL);
    end
  end
`else
  assign is_shift  = (alucontrol == ALU_SLL);
  assign work_step = work << 1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    load_imm     = 1'b0;
    load_shift   = 1'b0;
    commit_shift = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (is_shift && (shamt != '0)) begin
            load_shift = 1'b1;
            state_nxt  = SHIFT;
          end else begin
            load_imm  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == SHAMT_W'(1)) begin
          commit_shift = 1'b1;
          state_nxt    = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      work    <= '0;
      cnt     <= '0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
    end else begin
      if (load_shift) begin
        work <= b;
        cnt  <= shamt;
      end else if (busy) begin
        work <= work_step;
        cnt  <= cnt - SHAMT_W'(1);
      end

      // The final step is committed directly so done lands right after it
      if (load_imm) begin
        result  <= comb_y;
        zero    <= (comb_y == '0);
        illegal <= comb_illegal;
      end else if (commit_shift) begin
        result  <= work_step;
        zero    <= (work_step == '0);
        illegal <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
